// File: rtl/video_pkg.sv
// Shared constants and types for the CGA/Tandy video bus front end.
package video_pkg;

    localparam logic [14:0] OFS_CTRL   = 15'h008;
    localparam logic [14:0] OFS_COLOR  = 15'h009;
    localparam logic [14:0] OFS_STATUS = 15'h00A;
    localparam logic [14:0] OFS_DATA   = 15'h00E;

    localparam logic [7:0] IDX_BORDER   = 8'h02;
    localparam logic [7:0] IDX_MODE     = 8'h03;
    localparam logic [7:0] IDX_PAL_BASE = 8'h10;

    localparam logic [7:0] CTRL_RESET        = 8'h29;
    localparam int         CTRL_VIDEO_EN_BIT = 3;

    typedef enum logic [1:0] {
        WS_IDLE,
        WS_WAIT_A,
        WS_WAIT_B,
        WS_DONE
    } wait_state_t;

endpackage

// File: rtl/video_blink_gen.sv
// Cursor/character blink timing: free-running prescaler with a freeze input.
module video_blink_gen
    import video_pkg::*;
#(
    parameter logic [23:0] BLINK_MAX = 24'd0
) (
    input  logic clk,
    input  logic reset,
    input  logic freeze,
    output logic blink_cursor,
    output logic blink_char
);

    logic [23:0] count;

    // blink_char flips on each cursor rising edge, so it runs at half the cursor rate.
    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= 24'd0;
            blink_cursor <= 1'b0;
            blink_char   <= 1'b0;
        end else if (!freeze) begin
            if (count == BLINK_MAX) begin
                count        <= 24'd0;
                blink_cursor <= ~blink_cursor;
                if (!blink_cursor) begin
                    blink_char <= ~blink_char;
                end
            end else begin
                count <= count + 24'd1;
            end
        end
    end

endmodule

// File: rtl/video_bus_regs.sv
// ISA bus front end for the CGA/Tandy video path: decode, strobe sync,
// register file, indexed palette bank, framebuffer wait states and blink timers.
module video_bus_regs
    import video_pkg::*;
#(
    parameter logic [15:0] IO_BASE_ADDR       = 16'h3D0,
    parameter int          PAL_DEPTH          = 16,
    parameter int          PAL_WIDTH          = 4,
    parameter int          USE_BUS_WAIT       = 0,
    parameter logic [4:0]  WAIT_SLOT_A        = 5'd17,
    parameter logic [4:0]  WAIT_SLOT_B        = 5'd20,
    parameter logic [23:0] BLINK_MAX          = 24'd0,
    parameter int          NO_DISPLAY_DISABLE = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [14:0]                  bus_a,
    input  logic                         bus_ior_l,
    input  logic                         bus_iow_l,
    input  logic                         bus_memr_l,
    input  logic                         bus_memw_l,
    input  logic                         bus_aen,
    input  logic [7:0]                   bus_d,
    input  logic                         mem_cs,
    input  logic [4:0]                   clk_seq,
    input  logic                         vsync_l,
    input  logic                         display_enable,
    input  logic [7:0]                   crtc_bus_out,
    input  logic                         blink_freeze,
    output logic [7:0]                   bus_out,
    output logic                         bus_dir,
    output logic                         bus_rdy,
    output logic                         crtc_cs,
    output logic                         crtc_wr,
    output logic                         crtc_rd,
    output logic [7:0]                   control_reg,
    output logic [7:0]                   color_reg,
    output logic [7:0]                   tandy_mode_reg,
    output logic                         video_enabled,
    input  logic [$clog2(PAL_DEPTH)-1:0] pal_rd_idx,
    output logic [PAL_WIDTH-1:0]         pal_rd_data,
    output logic                         pal_set,
    output logic [PAL_WIDTH-1:0]         border_col,
    output logic                         blink_cursor,
    output logic                         blink_char
);

    localparam int          IDX_W   = $clog2(PAL_DEPTH);
    localparam logic [14:0] BASE    = IO_BASE_ADDR[14:0];
    localparam logic [7:0]  PAL_END = 8'(IDX_PAL_BASE + PAL_DEPTH);

    logic ior_s1, ior_s2;
    logic iow_s1, iow_s2, iow_s3;
    logic vsync_s1, vsync_s;
    logic de_s1, de_s;
    logic wr_pulse;

    logic ctrl_cs, color_cs, status_cs, data_cs;
    logic pal_hit;

    logic [7:0]           index_reg;
    logic [PAL_WIDTH-1:0] palette [PAL_DEPTH];

    wait_state_t state, state_next;
    logic        mem_strobe;

    // Synchronisers idle high so a reset never fakes a strobe edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ior_s1   <= 1'b1;
            ior_s2   <= 1'b1;
            iow_s1   <= 1'b1;
            iow_s2   <= 1'b1;
            iow_s3   <= 1'b1;
            vsync_s1 <= 1'b1;
            vsync_s  <= 1'b1;
            de_s1    <= 1'b1;
            de_s     <= 1'b1;
        end else begin
            ior_s1   <= bus_ior_l;
            ior_s2   <= ior_s1;
            iow_s1   <= bus_iow_l;
            iow_s2   <= iow_s1;
            iow_s3   <= iow_s2;
            vsync_s1 <= vsync_l;
            vsync_s  <= vsync_s1;
            de_s1    <= display_enable;
            de_s     <= de_s1;
        end
    end

    assign wr_pulse = iow_s3 & ~iow_s2;

    assign crtc_cs   = ~bus_aen & (bus_a[14:3] == BASE[14:3]);
    assign ctrl_cs   = ~bus_aen & (bus_a == BASE + OFS_CTRL);
    assign color_cs  = ~bus_aen & (bus_a == BASE + OFS_COLOR);
    assign status_cs = ~bus_aen & (bus_a == BASE + OFS_STATUS);
    assign data_cs   = ~bus_aen & (bus_a == BASE + OFS_DATA);

    assign crtc_wr = crtc_cs & ~iow_s2;
    assign crtc_rd = crtc_cs & ~ior_s2;

    always_comb begin
        bus_out = 8'h00;
        if (!bus_ior_l) begin
            if (status_cs) begin
                bus_out = {4'hF, vsync_s, 2'b10, ~de_s};
            end else if (crtc_cs && bus_a[0]) begin
                bus_out = crtc_bus_out;
            end
        end
    end

    assign bus_dir = (crtc_cs | status_cs) & ~bus_ior_l;

    assign pal_hit = (index_reg >= IDX_PAL_BASE) && (index_reg < PAL_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            control_reg    <= CTRL_RESET;
            color_reg      <= 8'h00;
            tandy_mode_reg <= 8'h00;
            index_reg      <= 8'h00;
            border_col     <= '0;
            pal_set        <= 1'b0;
            for (int i = 0; i < PAL_DEPTH; i++) begin
                palette[i] <= PAL_WIDTH'(i);
            end
        end else begin
            pal_set <= 1'b0;
            if (wr_pulse) begin
                if (ctrl_cs)  control_reg <= bus_d;
                if (color_cs) color_reg   <= bus_d;
                if (status_cs) index_reg  <= bus_d;
                if (data_cs) begin
                    if (pal_hit) begin
                        palette[index_reg[IDX_W-1:0]] <= bus_d[PAL_WIDTH-1:0];
                        pal_set                       <= 1'b1;
                    end else if (index_reg == IDX_BORDER) begin
                        border_col <= bus_d[PAL_WIDTH-1:0];
                    end else if (index_reg == IDX_MODE) begin
                        tandy_mode_reg <= bus_d;
                    end
                end
            end
        end
    end

    assign pal_rd_data   = palette[pal_rd_idx];
    assign video_enabled = control_reg[CTRL_VIDEO_EN_BIT] | (NO_DISPLAY_DISABLE != 0);

    assign mem_strobe = ~bus_memr_l | ~bus_memw_l;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A released strobe abandons the wait so the bus is never left stalled.
    always_comb begin
        state_next = state;
        bus_rdy    = 1'b1;
        case (state)
            WS_IDLE: begin
                if (mem_cs && mem_strobe) state_next = WS_WAIT_A;
            end
            WS_WAIT_A: begin
                bus_rdy = 1'b0;
                if (!mem_strobe)                 state_next = WS_IDLE;
                else if (clk_seq == WAIT_SLOT_A) state_next = WS_WAIT_B;
            end
            WS_WAIT_B: begin
                bus_rdy = 1'b0;
                if (!mem_strobe)                 state_next = WS_IDLE;
                else if (clk_seq == WAIT_SLOT_B) state_next = WS_DONE;
            end
            WS_DONE: begin
                if (!mem_strobe) state_next = WS_IDLE;
            end
            default: state_next = WS_IDLE;
        endcase
        if (USE_BUS_WAIT == 0) begin
            state_next = WS_IDLE;
        end
    end

    video_blink_gen #(
        .BLINK_MAX (BLINK_MAX)
    ) u_blink (
        .clk          (clk),
        .reset        (reset),
        .freeze       (blink_freeze),
        .blink_cursor (blink_cursor),
        .blink_char   (blink_char)
    );

endmodule

// File: tb/tb_video_bus_regs.sv
// Randomised register/palette traffic against a behavioural model, plus
// directed wait-state, reset and blink sequences.
`timescale 1ns/1ps
module tb_video_bus_regs;

    localparam logic [14:0] BASE  = 15'h3D0;
    localparam int          PDEP  = 16;
    localparam int          BPER  = 4;     // BLINK_MAX + 1

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] bus_a;
    logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen;
    logic [7:0]  bus_d;
    logic        mem_cs;
    logic [4:0]  clk_seq;
    logic        vsync_l, display_enable;
    logic [7:0]  crtc_bus_out;
    logic        blink_freeze;
    logic [7:0]  bus_out;
    logic        bus_dir, bus_rdy, crtc_cs, crtc_wr, crtc_rd;
    logic [7:0]  control_reg, color_reg, tandy_mode_reg;
    logic        video_enabled;
    logic [3:0]  pal_rd_idx;
    logic [3:0]  pal_rd_data;
    logic        pal_set;
    logic [3:0]  border_col;
    logic        blink_cursor, blink_char;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_ctrl, m_color, m_mode, m_index;
    logic [3:0] m_border;
    logic [3:0] m_pal [PDEP];

    always #5 clk = ~clk;

    video_bus_regs #(
        .IO_BASE_ADDR (16'h3D0),
        .USE_BUS_WAIT (1),
        .BLINK_MAX    (24'd3)
    ) dut (
        .clk (clk), .reset (reset), .bus_a (bus_a),
        .bus_ior_l (bus_ior_l), .bus_iow_l (bus_iow_l),
        .bus_memr_l (bus_memr_l), .bus_memw_l (bus_memw_l),
        .bus_aen (bus_aen), .bus_d (bus_d), .mem_cs (mem_cs), .clk_seq (clk_seq),
        .vsync_l (vsync_l), .display_enable (display_enable),
        .crtc_bus_out (crtc_bus_out), .blink_freeze (blink_freeze),
        .bus_out (bus_out), .bus_dir (bus_dir), .bus_rdy (bus_rdy),
        .crtc_cs (crtc_cs), .crtc_wr (crtc_wr), .crtc_rd (crtc_rd),
        .control_reg (control_reg), .color_reg (color_reg),
        .tandy_mode_reg (tandy_mode_reg), .video_enabled (video_enabled),
        .pal_rd_idx (pal_rd_idx), .pal_rd_data (pal_rd_data), .pal_set (pal_set),
        .border_col (border_col), .blink_cursor (blink_cursor), .blink_char (blink_char)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 8'h29; m_color = 8'h00; m_mode = 8'h00; m_index = 8'h00; m_border = 4'h0;
        for (int i = 0; i < PDEP; i++) m_pal[i] = 4'(i);
    endtask

    task automatic model_write(input logic [14:0] a, input logic [7:0] d, input logic aen,
                               output logic set);
        set = 1'b0;
        if (aen) return;
        if (a == BASE + 15'h8) m_ctrl = d;
        else if (a == BASE + 15'h9) m_color = d;
        else if (a == BASE + 15'hA) m_index = d;
        else if (a == BASE + 15'hE) begin
            if (int'(m_index) >= 16 && int'(m_index) < 16 + PDEP) begin
                m_pal[int'(m_index) - 16] = d[3:0];
                set = 1'b1;
            end else if (m_index == 8'd2) m_border = d[3:0];
            else if (m_index == 8'd3) m_mode = d;
        end
    endtask

    task automatic check_regs();
        int r;
        check_val("control", 32'(control_reg), 32'(m_ctrl));
        check_val("color", 32'(color_reg), 32'(m_color));
        check_val("tandy_mode", 32'(tandy_mode_reg), 32'(m_mode));
        check_val("border", 32'(border_col), 32'(m_border));
        check_val("video_en", 32'(video_enabled), 32'(m_ctrl[3]));
        r = $urandom_range(0, PDEP - 1);
        pal_rd_idx = 4'(r);
        #1 check_val("pal_rand", 32'(pal_rd_data), 32'(m_pal[r]));
    endtask

    task automatic pal_sweep();
        for (int i = 0; i < PDEP; i++) begin
            pal_rd_idx = 4'(i);
            #1 check_val("pal_sweep", 32'(pal_rd_data), 32'(m_pal[i]));
        end
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; returns at posedge+1 with the synchronisers idle.
    task automatic io_write(input logic [14:0] a, input logic [7:0] d, input logic aen);
        logic exp_set, crtc_hit;
        crtc_hit = !aen && (a[14:3] == BASE[14:3]);
        bus_a = a; bus_d = d; bus_aen = aen; bus_iow_l = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check_val("crtc_wr", 32'(crtc_wr), 32'(crtc_hit));
        check_val("pre_write_ctrl", 32'(control_reg), 32'(m_ctrl));
        model_write(a, d, aen, exp_set);
        @(posedge clk); @(negedge clk);
        check_val("pal_set", 32'(pal_set), 32'(exp_set));
        check_regs();
        @(posedge clk); #1 bus_iow_l = 1'b1; bus_aen = 1'b0;
        @(negedge clk);
        check_val("pal_set_clr", 32'(pal_set), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic io_read(input logic [14:0] a, input logic aen);
        logic status_hit, crtc_hit;
        logic [7:0] exp_out;
        status_hit = !aen && (a == BASE + 15'hA);
        crtc_hit   = !aen && (a[14:3] == BASE[14:3]);
        exp_out = 8'h00;
        if (status_hit) exp_out = {4'hF, vsync_l, 2'b10, ~display_enable};
        else if (crtc_hit && a[0]) exp_out = crtc_bus_out;
        bus_a = a; bus_aen = aen; bus_ior_l = 1'b0;
        #1;
        check_val("bus_out", 32'(bus_out), 32'(exp_out));
        check_val("bus_dir", 32'(bus_dir), 32'(status_hit || crtc_hit));
        @(posedge clk); @(posedge clk); @(negedge clk);
        check_val("crtc_rd", 32'(crtc_rd), 32'(crtc_hit));
        @(posedge clk); #1 bus_ior_l = 1'b1; bus_aen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_status_lines(input logic vs, input logic de);
        vsync_l = vs; display_enable = de;
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] pick_addr();
        case ($urandom_range(0, 6))
            0: return BASE + 15'h8;
            1: return BASE + 15'h9;
            2, 3: return BASE + 15'hA;
            4: return BASE + 15'hE;
            5: return BASE + 15'($urandom_range(0, 7));
            default: return 15'($urandom);
        endcase
    endfunction

    function automatic logic [7:0] pick_index();
        case ($urandom_range(0, 5))
            0, 1: return 8'(16 + $urandom_range(0, PDEP - 1));
            2: return 8'h02;
            3: return 8'h03;
            4: return ($urandom_range(0, 1) == 0) ? 8'h20 : 8'h0F;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [14:0] a;
        logic [7:0]  d;
        logic [4:0]  s3_seq [4];
        logic        s3_rdy [4];
        int          k;
        logic        f;

        reset = 1'b1; bus_a = '0; bus_ior_l = 1'b1; bus_iow_l = 1'b1;
        bus_memr_l = 1'b1; bus_memw_l = 1'b1; bus_aen = 1'b0; bus_d = '0;
        mem_cs = 1'b0; clk_seq = '0; vsync_l = 1'b1; display_enable = 1'b0;
        crtc_bus_out = '0; blink_freeze = 1'b0; pal_rd_idx = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check_regs();
        check_val("rst_bus_rdy", 32'(bus_rdy), 32'd1);
        check_val("rst_pal_set", 32'(pal_set), 32'd0);
        check_val("rst_cursor", 32'(blink_cursor), 32'd0);
        check_val("rst_char", 32'(blink_char), 32'd0);
        check_val("rst_bus_dir", 32'(bus_dir), 32'd0);
        pal_sweep();

        // control write held low for 10 cycles: one write, visible on the 4th cycle
        bus_a = BASE + 15'h8; bus_d = 8'h1A; bus_iow_l = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check_val("ctrl_cycle3", 32'(control_reg), 32'h29);
        @(posedge clk); @(negedge clk);
        check_val("ctrl_cycle4", 32'(control_reg), 32'h1A);
        bus_d = 8'h77;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check_val("ctrl_held", 32'(control_reg), 32'h1A);
        bus_iow_l = 1'b1;
        m_ctrl = 8'h1A;
        repeat (4) @(posedge clk);
        #1;

        io_write(BASE + 15'hA, 8'h15, 1'b0);
        io_write(BASE + 15'hE, 8'h0C, 1'b0);
        pal_rd_idx = 4'd5;
        #1 check_val("pal5", 32'(pal_rd_data), 32'hC);
        io_write(BASE + 15'hA, 8'h07, 1'b0);
        io_write(BASE + 15'hE, 8'hFF, 1'b0);
        io_write(BASE + 15'hA, 8'h1F, 1'b0);
        io_write(BASE + 15'hE, 8'h03, 1'b0);
        io_write(BASE + 15'hA, 8'h20, 1'b0);
        io_write(BASE + 15'hE, 8'h09, 1'b0);
        io_write(BASE + 15'hA, 8'h02, 1'b0);
        io_write(BASE + 15'hE, 8'hA6, 1'b0);
        io_write(BASE + 15'hE, 8'h5B, 1'b1);
        pal_sweep();

        set_status_lines(1'b0, 1'b1);
        io_read(BASE + 15'hA, 1'b0);
        io_read(BASE + 15'hA, 1'b1);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                crtc_bus_out = 8'($urandom);
                set_status_lines(1'($urandom), 1'($urandom));
                io_read(pick_addr(), ($urandom_range(0, 7) == 0));
            end else begin
                a = pick_addr();
                d = (a == BASE + 15'hA) ? pick_index() : 8'($urandom);
                io_write(a, d, ($urandom_range(0, 7) == 0));
            end
        end
        pal_sweep();

        // wait states: request at slot 3, ready returns after slot WAIT_SLOT_B is seen
        clk_seq = 5'd3; mem_cs = 1'b1; bus_memw_l = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            @(posedge clk); #1 clk_seq = clk_seq + 5'd1;
            @(negedge clk);
            check_val("rdy_full", 32'(bus_rdy), 32'((n + 3 - 1) >= 20));
        end
        bus_memw_l = 1'b1; mem_cs = 1'b0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            check_val("rdy_after_done", 32'(bus_rdy), 32'd1);
        end

        // strobe released mid-WAIT_A
        #1 clk_seq = 5'd3; mem_cs = 1'b1; bus_memr_l = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1 clk_seq = clk_seq + 5'd1;
            @(negedge clk);
            check_val("rdy_wait_a", 32'(bus_rdy), 32'd0);
        end
        bus_memr_l = 1'b1; mem_cs = 1'b0;
        @(posedge clk); @(negedge clk);
        check_val("rdy_abort", 32'(bus_rdy), 32'd1);

        // slot A already present on entry still costs one WAIT_A cycle
        s3_seq = '{5'd17, 5'd20, 5'd17, 5'd20};
        s3_rdy = '{1'b0, 1'b0, 1'b0, 1'b1};
        mem_cs = 1'b1; bus_memw_l = 1'b0;
        for (int i = 0; i < 4; i++) begin
            clk_seq = s3_seq[i];
            @(posedge clk); @(negedge clk);
            check_val("rdy_slot_entry", 32'(bus_rdy), 32'(s3_rdy[i]));
        end
        bus_memw_l = 1'b1; mem_cs = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset during WAIT_B and during a control write
        clk_seq = 5'd17; mem_cs = 1'b1; bus_memw_l = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 clk_seq = 5'd5;
        bus_a = BASE + 15'h8; bus_d = 8'h55; bus_iow_l = 1'b0;
        @(negedge clk);
        check_val("rdy_wait_b", 32'(bus_rdy), 32'd0);
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("rst_write_lost", 32'(control_reg), 32'h29);
        check_val("rst_rdy", 32'(bus_rdy), 32'd1);
        bus_iow_l = 1'b1; bus_memw_l = 1'b1; mem_cs = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        check_regs();
        check_val("rst2_cursor", 32'(blink_cursor), 32'd0);
        check_val("rst2_char", 32'(blink_char), 32'd0);
        check_val("rst2_pal_set", 32'(pal_set), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        pal_sweep();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("post_rst_ctrl", 32'(control_reg), 32'h29);

        // blink: k counts unfrozen clocks since reset release
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        k = 0;
        for (int c = 0; c < 90; c++) begin
            if (c >= 40 && c < 50) f = 1'b1;
            else if (c >= 60)      f = ($urandom_range(0, 2) == 0);
            else                   f = 1'b0;
            blink_freeze = f;
            @(posedge clk);
            if (!f) k++;
            @(negedge clk);
            check_val("blink_cursor", 32'(blink_cursor), 32'((k / BPER) % 2));
            check_val("blink_char", 32'(blink_char), 32'(((k + BPER) / (2 * BPER)) % 2));
        end
        blink_freeze = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
